// File: rtl/ospi_flash_mem_if.sv
// rtl/ospi_flash_mem_if.sv - command/response bus of the OSPI NOR-flash array model
interface ospi_flash_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              OSPI_CS;
    logic              HOLD_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              wel;
    logic              cmd_err;

    modport master (
        output OSPI_CS, HOLD_N, cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data, busy, wel, cmd_err
    );

    modport slave (
        input  OSPI_CS, HOLD_N, cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rd_valid, rd_data, busy, wel, cmd_err
    );
endinterface

// File: rtl/ospi_flash_mem.sv
// rtl/ospi_flash_mem.sv - behavioural OSPI NOR-flash array with WEL, program, sector erase and HOLD
module ospi_flash_mem #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    ospi_flash_mem_if.slave   bus
);
    localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WREN  = 3'd1;
    localparam logic [2:0] OP_WRDI  = 3'd2;
    localparam logic [2:0] OP_PROG  = 3'd3;
    localparam logic [2:0] OP_ERASE = 3'd4;
    localparam logic [2:0] OP_RDSR  = 3'd5;

    typedef enum logic [1:0] {IDLE, PROG, ERASE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ptr;
    logic              wel_r;
    logic              rd_valid_r;
    logic              err_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              busy_w;

    // Command decode; HOLD_N low blocks every accept, which freezes everything below.
    logic accept, is_idle, do_read, do_rdsr, do_wren, do_wrdi, do_prog, do_erase, do_err;
    logic prog_done, erase_last;

    assign accept     = !bus.OSPI_CS && bus.HOLD_N && bus.cmd_valid;
    assign is_idle    = (state == IDLE);
    assign do_rdsr    = accept && (bus.cmd_op == OP_RDSR);
    assign do_read    = accept && is_idle && (bus.cmd_op == OP_READ);
    assign do_wren    = accept && is_idle && (bus.cmd_op == OP_WREN);
    assign do_wrdi    = accept && is_idle && (bus.cmd_op == OP_WRDI);
    assign do_prog    = accept && is_idle && (bus.cmd_op == OP_PROG) && wel_r;
    assign do_erase   = accept && is_idle && (bus.cmd_op == OP_ERASE) && wel_r;
    assign do_err     = accept && (bus.cmd_op != OP_RDSR) &&
                        (!is_idle || (bus.cmd_op > OP_RDSR) ||
                         (((bus.cmd_op == OP_PROG) || (bus.cmd_op == OP_ERASE)) && !wel_r));
    assign prog_done  = (state == PROG) && (cnt == '0);
    assign erase_last = (state == ERASE) && (&ptr[SECTOR_W-1:0]);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; nothing moves while HOLD_N is low.
    always_comb begin
        state_nxt = state;
        if (bus.HOLD_N) begin
            case (state)
                IDLE:    if (do_prog) state_nxt = PROG;
                         else if (do_erase) state_nxt = ERASE;
                PROG:    if (prog_done) state_nxt = IDLE;
                ERASE:   if (erase_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs derived from state and the registered pulses.
    always_comb begin
        busy_w        = (state != IDLE);
        bus.busy      = busy_w;
        bus.cmd_ready = !bus.OSPI_CS && bus.HOLD_N;
        bus.rd_valid  = rd_valid_r && bus.HOLD_N;
        bus.cmd_err   = err_r && bus.HOLD_N;
        bus.wel       = wel_r;
        bus.rd_data   = rd_data_r;
    end

    // Control registers: WEL, program counter, erase pointer, read/status response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wel_r      <= 1'b0;
            cnt        <= '0;
            ptr        <= '0;
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
            rd_data_r  <= '1;
        end else begin
            rd_valid_r <= do_read || do_rdsr;
            err_r      <= do_err;
            if (do_read) rd_data_r <= mem[bus.cmd_addr];
            if (do_rdsr) rd_data_r <= {{(DATA_W-2){1'b0}}, wel_r, busy_w};
            if (bus.HOLD_N) begin
                if (do_wren) wel_r <= 1'b1;
                if (do_wrdi) wel_r <= 1'b0;
                if (prog_done || erase_last) wel_r <= 1'b0;
                if (do_prog) cnt <= CNT_W'(PROG_CYCLES - 1);
                else if ((state == PROG) && (cnt != '0)) cnt <= cnt - 1'b1;
                if (do_erase) ptr <= {bus.cmd_addr[ADDR_W-1:SECTOR_W], {SECTOR_W{1'b0}}};
                else if (state == ERASE) ptr <= ptr + 1'b1;
            end
        end
    end

    // Array writes; contents survive reset so a partial erase stays partial.
    always_ff @(posedge clk) begin
        if (bus.HOLD_N) begin
            if (do_prog) mem[bus.cmd_addr] <= mem[bus.cmd_addr] & bus.cmd_wdata;
            if (state == ERASE) mem[ptr] <= '1;
        end
    end
endmodule

// File: tb/tb_ospi_flash_mem.sv
// tb/tb_ospi_flash_mem.sv - randomized and directed self-checking bench for ospi_flash_mem
module tb_ospi_flash_mem;
    localparam int PROG = 4;
    localparam int SEC  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ospi_flash_mem_if #(.DATA_W(8), .ADDR_W(12)) bus();

    ospi_flash_mem #(.DATA_W(8), .ADDR_W(12), .SECTOR_W(4), .PROG_CYCLES(PROG)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  ref_mem [0:4095];
    bit          m_wel = 0;
    int          busy_left = 0;
    bit          m_rv = 0;
    bit          m_err = 0;
    logic [7:0]  m_rd = 8'hFF;
    bit          erasing = 0;
    int          er_base = 0;
    logic [7:0]  er_old [0:SEC-1];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model evaluates the edge with pre-edge state, then outputs are checked.
    task automatic cycle();
        bit bpre, wpre;
        int a;
        @(posedge clk);
        m_rv = 0;
        m_err = 0;
        if (bus.HOLD_N) begin
            bpre = busy_left > 0;
            wpre = m_wel;
            a = int'(bus.cmd_addr);
            if (!bus.OSPI_CS && bus.cmd_valid) begin
                if (bus.cmd_op == 3'd5) begin
                    m_rv = 1;
                    m_rd = {6'b0, wpre, bpre};
                end else if (bpre || bus.cmd_op > 3'd5) begin
                    m_err = 1;
                end else begin
                    case (bus.cmd_op)
                        3'd0: begin m_rv = 1; m_rd = ref_mem[a]; end
                        3'd1: m_wel = 1;
                        3'd2: m_wel = 0;
                        3'd3: if (!wpre) m_err = 1;
                              else begin
                                  ref_mem[a] = ref_mem[a] & bus.cmd_wdata;
                                  busy_left = PROG;
                                  erasing = 0;
                              end
                        default: if (!wpre) m_err = 1;
                              else begin
                                  er_base = (a / SEC) * SEC;
                                  for (int i = 0; i < SEC; i++) begin
                                      er_old[i] = ref_mem[er_base + i];
                                      ref_mem[er_base + i] = 8'hFF;
                                  end
                                  busy_left = SEC;
                                  erasing = 1;
                              end
                    endcase
                end
            end
            if (bpre) begin
                busy_left--;
                if (busy_left == 0) m_wel = 0;
            end
        end
        #1;
        expect_eq("cmd_ready", bus.cmd_ready, !bus.OSPI_CS && bus.HOLD_N);
        expect_eq("busy", bus.busy, busy_left > 0);
        expect_eq("wel", bus.wel, m_wel);
        expect_eq("rd_valid", bus.rd_valid, m_rv && bus.HOLD_N);
        expect_eq("cmd_err", bus.cmd_err, m_err && bus.HOLD_N);
        expect_eq("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic drive_idle();
        bus.OSPI_CS   = 1'b0;
        bus.HOLD_N    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 12'h0;
        bus.cmd_wdata = 8'h0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [11:0] a, input logic [7:0] d);
        bus.OSPI_CS   = 1'b0;
        bus.HOLD_N    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        cycle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_left > 0 && n < 200) begin
            cycle();
            n++;
        end
        expect_eq("idle_bound", bus.busy, 1'b0);
    endtask

    task automatic program_word(input logic [11:0] a, input logic [7:0] d);
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd3, a, d);
        drive_idle();
        wait_idle();
    endtask

    task automatic read_expect(input string tag, input logic [11:0] a, input logic [7:0] exp);
        cmd(3'd0, a, 8'h0);
        drive_idle();
        expect_eq(tag, bus.rd_data, exp);
    endtask

    // Assert reset after the current edge and bring the model to its reset state.
    task automatic apply_reset(input bit check_ready);
        reset_n = 1'b0;
        #1;
        if (erasing && busy_left > 0) begin
            for (int i = SEC - busy_left; i < SEC; i++) ref_mem[er_base + i] = er_old[i];
        end
        erasing = 0;
        busy_left = 0;
        m_wel = 0;
        m_rv = 0;
        m_err = 0;
        m_rd = 8'hFF;
        if (check_ready) expect_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);
        expect_eq("rst_busy", bus.busy, 1'b0);
        expect_eq("rst_wel", bus.wel, 1'b0);
        expect_eq("rst_rd_valid", bus.rd_valid, 1'b0);
        expect_eq("rst_cmd_err", bus.cmd_err, 1'b0);
        expect_eq("rst_rd_data", bus.rd_data, 8'hFF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_idle();
    endtask

    initial begin
        int n;
        logic [7:0] d;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'hFF;
        drive_idle();
        bus.OSPI_CS = 1'b1;
        @(posedge clk);
        #1;
        apply_reset(1'b1);

        // Bring the whole array to a known erased state.
        for (int s = 0; s < 256; s++) begin
            cmd(3'd1, 12'h0, 8'h0);
            cmd(3'd4, 12'(s * SEC), 8'h0);
            drive_idle();
            wait_idle();
        end

        // Preloaded READ
        program_word(12'h010, 8'hA5);
        read_expect("read_010", 12'h010, 8'hA5);
        expect_eq("read_010_valid", bus.rd_valid, 1'b1);
        cycle();
        expect_eq("read_valid_pulse", bus.rd_valid, 1'b0);

        // Program without WEL, then AND-only program
        program_word(12'h020, 8'hF3);
        cmd(3'd3, 12'h020, 8'h0F);
        drive_idle();
        expect_eq("prog_nowel_err", bus.cmd_err, 1'b1);
        read_expect("prog_nowel_mem", 12'h020, 8'hF3);
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd3, 12'h020, 8'h0F);
        drive_idle();
        n = 0;
        while (bus.busy && n < 50) begin n++; cycle(); end
        expect_eq("prog_busy_len", n, PROG);
        expect_eq("prog_wel_after", bus.wel, 1'b0);
        read_expect("prog_and", 12'h020, 8'h03);

        // Sector erase with neighbours, status and rejected read mid-erase
        program_word(12'h02F, 8'h12);
        program_word(12'h040, 8'h34);
        for (int i = 0; i < SEC; i++) program_word(12'h030 + 12'(i), 8'($urandom));
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd4, 12'h035, 8'h0);
        cmd(3'd5, 12'h0, 8'h0);
        expect_eq("rdsr_mid_erase", bus.rd_data, 8'h03);
        cmd(3'd0, 12'h031, 8'h0);
        expect_eq("read_mid_erase_err", bus.cmd_err, 1'b1);
        expect_eq("read_mid_erase_rv", bus.rd_valid, 1'b0);
        drive_idle();
        wait_idle();
        read_expect("erase_below", 12'h02F, 8'h12);
        read_expect("erase_above", 12'h040, 8'h34);
        for (int i = 0; i < SEC; i++) read_expect("erase_word", 12'h030 + 12'(i), 8'hFF);

        // HOLD_N mid-program stretches busy
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd3, 12'h050, 8'h5A);
        n = 1;
        bus.HOLD_N = 1'b0;
        for (int i = 0; i < 5; i++) begin cycle(); if (bus.busy) n++; end
        bus.HOLD_N = 1'b1;
        while (bus.busy && n < 50) begin cycle(); if (bus.busy) n++; end
        expect_eq("hold_busy_len", n, PROG + 5);
        read_expect("hold_prog_mem", 12'h050, 8'h5A);

        // OSPI_CS high does not abort an erase
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd4, 12'h05C, 8'h0);
        bus.OSPI_CS = 1'b1;
        wait_idle();
        drive_idle();
        read_expect("cs_erase_mem", 12'h050, 8'hFF);

        // Reset during erase keeps the words already erased
        for (int i = 0; i < SEC; i++) program_word(12'h030 + 12'(i), 8'h40 + 8'(i));
        cmd(3'd1, 12'h0, 8'h0);
        cmd(3'd4, 12'h035, 8'h0);
        drive_idle();
        for (int i = 0; i < 6; i++) cycle();
        apply_reset(1'b0);
        for (int i = 0; i < SEC; i++) begin
            d = (i < 6) ? 8'hFF : 8'h40 + 8'(i);
            read_expect("partial_erase", 12'h030 + 12'(i), d);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bus.OSPI_CS   = ($urandom_range(0, 9) == 0);
            bus.HOLD_N    = ($urandom_range(0, 9) != 0);
            bus.cmd_valid = ($urandom_range(0, 9) < 6);
            bus.cmd_op    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) bus.cmd_op = 3'd1;
            bus.cmd_addr  = 12'($urandom_range(0, 255));
            bus.cmd_wdata = 8'($urandom);
            cycle();
        end
        drive_idle();
        wait_idle();
        for (int a = 0; a < 256; a += 7) read_expect("final_read", 12'(a), ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
